// File: rtl/l2_writeback_buffer.sv
// Posted-write buffer between L2 and dmem: circular FIFO with word-address
// coalescing, youngest-match read forwarding, req/ack drain and flush.
module l2_writeback_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wb_valid,
  input  logic [ADDR_W-1:0]          wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  output logic                       wb_ready,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic                       rd_hit,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_ack,
  input  logic                       flush,
  output logic                       flush_done,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] ent_addr [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0]  ent_valid;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              flush_pending;

  logic              coal_hit;
  logic [PTR_W-1:0]  coal_idx;
  logic              fwd_hit;
  logic [PTR_W-1:0]  fwd_idx;
  logic [PTR_W-1:0]  idx;

  logic              push;
  logic              push_new;
  logic              pop;
  logic              issue;
  logic              flush_req;
  logic              flush_fire;
  logic              unused_lsb;

  assign unused_lsb = ^rd_addr[1:0];

  assign wb_ready = (count != CNT_W'(DEPTH));
  assign push     = wb_valid && wb_ready;
  assign push_new = push && !coal_hit;
  assign pop      = (state == S_BUSY) && mem_ack;
  assign issue    = (state == S_IDLE) && (count != '0);

  // Walk oldest to youngest from rd_ptr so the last match found is the youngest.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = wr_ptr;
    fwd_hit  = 1'b0;
    fwd_idx  = rd_ptr;
    idx      = rd_ptr;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if (ent_valid[idx] && (ent_addr[idx][ADDR_W-1:2] == wb_addr[ADDR_W-1:2]) &&
          !((state == S_BUSY) && (k == 0))) begin
        coal_hit = 1'b1;
        coal_idx = idx;
      end
      if (ent_valid[idx] && (ent_addr[idx][ADDR_W-1:2] == rd_addr[ADDR_W-1:2])) begin
        fwd_hit = 1'b1;
        fwd_idx = idx;
      end
    end
  end

  assign rd_hit  = fwd_hit;
  assign rd_data = fwd_hit ? ent_data[fwd_idx] : '0;

  assign flush_req  = flush || flush_pending;
  assign flush_fire = flush_req && (count == '0) && (state == S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
      end
      ent_valid     <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      state         <= S_IDLE;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      flush_pending <= 1'b0;
      flush_done    <= 1'b0;
    end else begin
      if (push) begin
        if (coal_hit) begin
          ent_data[coal_idx] <= wb_data;
        end else begin
          ent_addr[wr_ptr]  <= wb_addr;
          ent_data[wr_ptr]  <= wb_data;
          ent_valid[wr_ptr] <= 1'b1;
          wr_ptr            <= wr_ptr + 1'b1;
        end
      end

      if (pop) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + 1'b1;
      end

      case ({push_new, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      case (state)
        S_IDLE: begin
          if (issue) begin
            // A same-edge coalesce into the head must reach dmem, not the stale word.
            mem_addr  <= ent_addr[rd_ptr];
            mem_wdata <= (push && coal_hit && (coal_idx == rd_ptr)) ? wb_data
                                                                    : ent_data[rd_ptr];
            mem_req   <= 1'b1;
            state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      flush_done    <= flush_fire;
      flush_pending <= flush_req && !flush_fire;
    end
  end

endmodule

// File: tb/tb_l2_writeback_buffer.sv
// Bench for l2_writeback_buffer: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_l2_writeback_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wb_valid = 1'b0;
  logic [31:0] wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        wb_ready;
  logic [31:0] rd_addr = '0;
  logic        rd_hit;
  logic [31:0] rd_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic        flush = 1'b0;
  logic        flush_done;
  logic [2:0]  count;

  always #5 clk = ~clk;

  l2_writeback_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_data(rd_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .flush(flush), .flush_done(flush_done), .count(count)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  bit          m_busy, m_req, m_fpend, m_fdone;
  logic [31:0] m_addr, m_wdata;

  int          n_cmp = 0;
  int          n_err = 0;
  int          fd_cnt = 0;
  bit          prev_req = 1'b0;
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy = 0; m_req = 0; m_fpend = 0; m_fdone = 0;
    m_addr = '0; m_wdata = '0;
  endtask

  // One clock edge of the reference behaviour, using pre-edge state.
  task automatic model_edge();
    int   n;
    int   lo;
    bit   push, issue, ack, fire, hit;
    ent_t e;
    if (!reset) begin
      model_reset();
      return;
    end
    n     = mq.size();
    push  = wb_valid && (n != DEPTH);
    issue = !m_busy && (n != 0);
    ack   = m_busy && mem_ack;
    fire  = (m_fpend || flush) && (n == 0) && !m_busy;
    if (push) begin
      hit = 0;
      lo  = m_busy ? 1 : 0;
      for (int j = n - 1; j >= lo; j--) begin
        if (mq[j].addr[31:2] == wb_addr[31:2]) begin
          e = mq[j];
          e.data = wb_data;
          mq[j] = e;
          hit = 1;
          break;
        end
      end
      if (!hit) mq.push_back('{addr: wb_addr, data: wb_data});
    end
    if (ack) begin
      void'(mq.pop_front());
      m_busy = 0;
      m_req  = 0;
    end
    if (issue) begin
      m_busy  = 1;
      m_req   = 1;
      m_addr  = mq[0].addr;
      m_wdata = mq[0].data;
    end
    m_fdone = fire;
    m_fpend = (m_fpend || flush) && !fire;
  endtask

  task automatic compare_all();
    bit          h;
    logic [31:0] d;
    h = 0;
    d = '0;
    for (int j = 0; j < mq.size(); j++) begin
      if (mq[j].addr[31:2] == rd_addr[31:2]) begin
        h = 1;
        d = mq[j].data;
      end
    end
    chk("count",      64'(count),      64'(mq.size()));
    chk("wb_ready",   64'(wb_ready),   64'(mq.size() != DEPTH));
    chk("mem_req",    64'(mem_req),    64'(m_req));
    chk("mem_addr",   64'(mem_addr),   64'(m_addr));
    chk("mem_wdata",  64'(mem_wdata),  64'(m_wdata));
    chk("flush_done", 64'(flush_done), 64'(m_fdone));
    chk("rd_hit",     64'(rd_hit),     64'(h));
    chk("rd_data",    64'(rd_data),    64'(d));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    if (mem_req && !prev_req) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
    end
    prev_req = mem_req;
    if (flush_done) fd_cnt++;
  endtask

  task automatic push_word(input logic [31:0] a, input logic [31:0] d);
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_data  = d;
    cycle();
    wb_valid = 1'b0;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic wait_req();
    int tries;
    tries = 0;
    while (!mem_req && tries < 20) begin
      cycle();
      tries++;
    end
    if (!mem_req) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_req: mem_req still 0 after %0d cycles", tries);
    end
  endtask

  task automatic drain();
    mem_ack = 1'b1;
    repeat (12) cycle();
    mem_ack = 1'b0;
    chk("drain_count", 64'(count), 64'd0);
  endtask

  initial begin
    logic [31:0] exp_order [5];
    exp_order[0] = 32'h10; exp_order[1] = 32'h14; exp_order[2] = 32'h18;
    exp_order[3] = 32'h1C; exp_order[4] = 32'h20;

    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_mem_req",  64'(mem_req),  64'd0);
    chk("rst_count",    64'(count),    64'd0);
    chk("rst_wb_ready", 64'(wb_ready), 64'd1);
    chk("rst_rd_hit",   64'(rd_hit),   64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    reset = 1'b1;
    cycle();

    // Basic drain
    push_word(32'h100, 32'hAAAA0001);
    chk("basic_no_req_yet", 64'(mem_req), 64'd0);
    cycle();
    chk("basic_req",   64'(mem_req),   64'd1);
    chk("basic_addr",  64'(mem_addr),  64'h100);
    chk("basic_wdata", 64'(mem_wdata), 64'hAAAA0001);
    repeat (3) begin
      cycle();
      chk("basic_hold_req",  64'(mem_req),   64'd1);
      chk("basic_hold_data", 64'(mem_wdata), 64'hAAAA0001);
    end
    mem_ack = 1'b1;
    cycle();
    mem_ack = 1'b0;
    chk("basic_count0", 64'(count), 64'd0);
    chk("basic_req0",   64'(mem_req), 64'd0);

    // Fill and wrap
    clear_log();
    for (int i = 0; i < 4; i++) push_word(32'h10 + 32'(4 * i), 32'h1000 + 32'(i));
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_ready", 64'(wb_ready), 64'd0);
    push_word(32'h30, 32'hDEAD);
    chk("fill_fifth_ignored", 64'(count), 64'd4);
    mem_ack = 1'b1;
    cycle();
    mem_ack = 1'b0;
    chk("fill_after_ack", 64'(count), 64'd3);
    push_word(32'h20, 32'h55);
    chk("wrap_count", 64'(count), 64'd4);
    drain();
    chk("wrap_nwrites", 64'(log_addr.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      if (i < log_addr.size()) chk("wrap_order", 64'(log_addr[i]), 64'(exp_order[i]));

    // Coalesce and forward
    clear_log();
    push_word(32'h40, 32'd1);
    push_word(32'h44, 32'd2);
    push_word(32'h44, 32'd3);
    chk("coal_count", 64'(count), 64'd2);
    rd_addr = 32'h46;
    #1;
    chk("fwd_hit",  64'(rd_hit),  64'd1);
    chk("fwd_data", 64'(rd_data), 64'd3);
    rd_addr = 32'h48;
    #1;
    chk("fwd_miss_hit",  64'(rd_hit),  64'd0);
    chk("fwd_miss_data", 64'(rd_data), 64'd0);
    drain();
    chk("coal_nwrites", 64'(log_data.size()), 64'd2);
    if (log_data.size() == 2) begin
      chk("coal_w0", 64'(log_data[0]), 64'd1);
      chk("coal_w1", 64'(log_data[1]), 64'd3);
    end

    // In-flight exclusion
    clear_log();
    push_word(32'h80, 32'd5);
    cycle();
    chk("inflight_busy", 64'(mem_req), 64'd1);
    push_word(32'h80, 32'd6);
    chk("inflight_count", 64'(count), 64'd2);
    rd_addr = 32'h80;
    #1;
    chk("inflight_fwd", 64'(rd_data), 64'd6);
    drain();
    chk("inflight_nwrites", 64'(log_data.size()), 64'd2);
    if (log_data.size() == 2) begin
      chk("inflight_w0", 64'(log_data[0]), 64'd5);
      chk("inflight_w1", 64'(log_data[1]), 64'd6);
    end

    // Flush with slow acks
    fd_cnt = 0;
    push_word(32'h200, 32'd11);
    push_word(32'h204, 32'd12);
    push_word(32'h208, 32'd13);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_req();
      repeat (2) cycle();
      mem_ack = 1'b1;
      cycle();
      mem_ack = 1'b0;
    end
    repeat (4) cycle();
    chk("flush_pulses", 64'(fd_cnt), 64'd1);

    // Flush while empty
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_empty_done", 64'(flush_done), 64'd1);
    cycle();
    chk("flush_empty_single", 64'(flush_done), 64'd0);

    // Async reset mid-write
    push_word(32'h300, 32'd7);
    push_word(32'h304, 32'd8);
    chk("rst_pre_count", 64'(count), 64'd2);
    chk("rst_pre_req",   64'(mem_req), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_req_drop", 64'(mem_req), 64'd0);
    chk("async_count0",   64'(count),   64'd0);
    model_reset();
    cycle();
    reset = 1'b1;
    clear_log();
    prev_req = 1'b0;
    repeat (6) cycle();
    chk("post_rst_req",    64'(mem_req), 64'd0);
    chk("post_rst_writes", 64'(log_addr.size()), 64'd0);

    // Random traffic over a small address pool to provoke coalescing
    repeat (2000) begin
      wb_valid = ($urandom % 2) == 0;
      wb_addr  = 32'h1000 + 32'(($urandom % 6) * 4) + 32'($urandom % 4);
      wb_data  = $urandom;
      rd_addr  = 32'h1000 + 32'(($urandom % 7) * 4) + 32'($urandom % 4);
      mem_ack  = ($urandom % 3) == 0;
      flush    = ($urandom % 25) == 0;
      cycle();
    end
    wb_valid = 1'b0;
    flush    = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/l2_writeback_buffer.md
# l2_writeback_buffer

Posted-write buffer between the L2 cache subsystem and data memory. Accepts entries evicted or written through by L2 (`data_to_dmem` / `address_to_dmem`), queues them in a small FIFO, and drains them to dmem over a req/ack handshake. Provides same-cycle read forwarding so an L2 load miss never reads stale dmem data. Supports flush-to-empty with a completion pulse.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-low reset.
- `wb_valid` in 1: push request from L2.
- `wb_addr` in ADDR_W: byte address of the pushed word.
- `wb_data` in DATA_W: pushed word.
- `wb_ready` out 1: push accepted this cycle when high; `wb_ready = (count != DEPTH)`.
- `rd_addr` in ADDR_W: L2 load-miss lookup address.
- `rd_hit` out 1: combinational; a buffered entry matches `rd_addr`.
- `rd_data` out DATA_W: combinational; data of the youngest matching entry, 0 when no hit.
- `mem_req` out 1: write request to dmem (registered).
- `mem_addr` out ADDR_W: write address (registered).
- `mem_wdata` out DATA_W: write data (registered).
- `mem_ack` in 1: dmem has accepted the current write.
- `flush` in 1: one-cycle pulse requesting a full drain.
- `flush_done` out 1: one-cycle pulse when the drain completes.
- `count` out $clog2(DEPTH+1): occupied entries.

## Operation
- Storage: circular FIFO with `wr_ptr`, `rd_ptr` (log2 DEPTH bits, wrap modulo DEPTH), and `count`. Each entry holds addr, data and valid.
- Match rule: entries match on word address, `addr[ADDR_W-1:2]`. Byte offset is ignored.
- Push: occurs when `wb_valid && wb_ready`.
  - Coalesce: if a valid entry that is not in flight matches, its data is overwritten in place. Count and pointers are unchanged; the youngest such entry wins.
  - Otherwise the word is written at `wr_ptr`, then `wr_ptr+1` and `count+1`.
  - A full buffer deasserts `wb_ready` even on a coalesce match.
- Forwarding: search all valid entries, including the in-flight head, and return the youngest match (the one closest to `wr_ptr`). It is purely combinational.
- Drain FSM has two states: IDLE and BUSY.
  - IDLE with `count != 0`: load `mem_addr`/`mem_wdata` from the head, set `mem_req=1`, go to BUSY. The head is then marked in flight.
  - BUSY: `mem_req`, `mem_addr` and `mem_wdata` are held stable until `mem_ack` is sampled high.
  - On ack: invalidate the head, `rd_ptr+1`, `count-1`, `mem_req=0`, return to IDLE.
  - Re-issue happens no earlier than the cycle after return to IDLE, so there is one idle cycle between writes.
- Simultaneous push and ack-pop in one cycle: count is unchanged, and both pointers advance.
  - `wb_ready` is derived from the registered count, so a pop does not free a slot for a same-cycle push.
- Flush:
  - `flush` sets `flush_pending`.
  - Pushes during a pending flush are still accepted and drained.
  - When `flush_pending && count==0 && state==IDLE`, pulse `flush_done` for 1 cycle and clear `flush_pending`.
  - `flush` while `flush_pending` is already set has no extra effect.
- `mem_ack` while IDLE is ignored.

## Timing
- Reset (asynchronous on `reset` low):
  - Outputs: `mem_req=0`, `mem_addr=0`, `mem_wdata=0`, `flush_done=0`, `count=0`, `wb_ready=1`, `rd_hit=0`, `rd_data=0`.
  - Internal state: pointers 0, all valid=0, FSM IDLE, `flush_pending=0`.
- Reset mid-transaction drops `mem_req` immediately. Buffered and in-flight data are discarded, and dmem must tolerate the aborted request.
- Push to memory: an entry pushed at edge N into an empty buffer gives `mem_req=1` after edge N+1.
- Ack to next request: with ack sampled at edge M, `mem_req=0` after M and the next `mem_req=1` after M+1.
- Forwarding latency: `rd_hit` reflects a push one cycle after its accepting edge. It does not see a same-cycle push.
- Flush completion: `flush_done` asserts after the edge where the idle-and-empty condition first holds. Flush on an empty idle buffer gives `flush_done` after the next edge.
- Throughput with a zero-wait dmem (ack the cycle after req) is one write per 2 cycles.

## Test plan
- Basic drain: push (0x100, 0xAAAA0001).
  - Expect `mem_req` with `mem_addr=0x100` and `mem_wdata=0xAAAA0001` one cycle later.
  - Hold ack low for 3 cycles: outputs stay stable. Ack, then `count=0`.
- Fill and wrap, DEPTH=4:
  - Push 0x10, 0x14, 0x18, 0x1C with ack held low: `wb_ready=0`, and a fifth push is ignored.
  - Ack once, then push 0x20 (entry lands at index 0).
  - Expect dmem write order 0x10, 0x14, 0x18, 0x1C, 0x20.
- Coalesce and forward:
  - Push (0x40, 1), then (0x44, 2), then (0x44, 3) with ack held low: count=2.
  - `rd_addr=0x46` gives `rd_hit=1`, `rd_data=3`. `rd_addr=0x48` gives `rd_hit=0`, `rd_data=0`.
- In-flight exclusion:
  - Push (0x80, 5), wait until BUSY, push (0x80, 6) with ack held low: count=2.
  - `rd_data` at 0x80 = 6. dmem sees 5, then 6.
- Flush:
  - Push 3 entries, pulse `flush`, and ack each request after 2 cycles.
  - `flush_done` pulses exactly once, after the third ack's return to IDLE.
  - Flush while empty: `flush_done` appears the next cycle.
- Async reset mid-write:
  - Assert `reset=0` while BUSY with count=2, between clock edges.
  - `mem_req` falls without waiting for a clock edge. After release, count=0 and no further requests are issued.
